// File: rtl/dmem_responder.sv
// Word-addressed RAM target: one request in flight, response WAIT_CYCLES+1 cycles after accept.
// Response is held stable while rsp_ready is low; req_ready stays low until the response handshake.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  req_t        lat, cur;
  logic        accept, commit, cur_err;
  logic [AW-1:0] cur_idx;
  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = S_RESP;
            commit    = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accept edge, so use the live request.
  always_comb begin
    if (state == S_IDLE) begin
      cur.we    = req_we;
      cur.addr  = req_addr;
      cur.wdata = req_wdata;
    end else begin
      cur = lat;
    end
  end

  assign cur_idx = cur.addr[AW+1:2];
  assign cur_err = (cur.addr[1:0] != 2'b00) || (cur.addr[31:AW+2] != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat       <= '0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) lat <= cur;
      if (commit) begin
        rsp_err   <= cur_err;
        rsp_rdata <= (!cur_err && !cur.we) ? mem[cur_idx] : 32'd0;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'd0;
      end
    end
  end

  // Gated by reset so a request presented during reset can never write.
  always_ff @(posedge clk) begin
    if (reset && commit && !cur_err && cur.we) mem[cur_idx] <= cur.wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a 2-wait-state responder for most cases and a 0-wait-state one for back-to-back.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a rising edge. Performs one request and its response handshake.
  task automatic xfer(input bit z, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input int exp_k, input logic exp_err, input logic [31:0] exp_rd,
                      input string tag);
    int   k;
    logic ok, vld;
    if (z) begin z_req_valid = 1'b1; z_req_we = we; z_req_addr = a; z_req_wdata = d; end
    else   begin req_valid   = 1'b1; req_we   = we; req_addr   = a; req_wdata   = d; end
    k = 0;
    do begin
      @(negedge clk);
      ok = z ? z_req_ready : req_ready;
      @(posedge clk); #1;
      k++;
    end while (!ok && k < 20);
    chk({tag, "_accept"}, 32'(ok), 32'd1);
    if (z) z_req_valid = 1'b0; else req_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      vld = z ? z_rsp_valid : rsp_valid;
    end while (!vld && k < 20);
    chk({tag, "_latency"}, 32'(k), 32'(exp_k));
    chk({tag, "_err"}, 32'(z ? z_rsp_err : rsp_err), 32'(exp_err));
    chk({tag, "_rdata"}, z ? z_rsp_rdata : rsp_rdata, exp_rd);
    if (!z) rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Store then load with two wait states
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 1'b0, 32'h0, "st10");
    xfer(0, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF, "ld10");

    // Error cases: misaligned store must not touch word 0x10, out-of-range load reads zero
    xfer(0, 1'b1, 32'h12, 32'h0BADF00D, 3, 1'b1, 32'h0, "st12_mis");
    xfer(0, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF, "ld10_after_err");
    xfer(0, 1'b0, 32'h400, 32'h0, 3, 1'b1, 32'h0, "ld400_range");
    xfer(0, 1'b0, 32'h13, 32'h0, 3, 1'b1, 32'h0, "ld13_mis");

    // Backpressure: hold the response, offer another request meanwhile
    xfer(0, 1'b1, 32'h20, 32'hAAAA5555, 3, 1'b0, 32'h0, "st20");
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_addr = 32'h20;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_reach_resp", 32'(rsp_valid), 32'd1);
    held = rsp_rdata;
    chk("bp_rdata", held, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_no_accept_valid", 32'(rsp_valid), 32'd0);
      chk("bp_no_accept_ready", 32'(req_ready), 32'd1);
    end
    @(posedge clk); #1;

    // Zero wait states: preload, then back-to-back loads
    xfer(1, 1'b1, 32'h0, 32'h11111111, 1, 1'b0, 32'h0, "z_st0");
    xfer(1, 1'b1, 32'h4, 32'h22222222, 1, 1'b0, 32'h0, "z_st4");
    z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h0;
    @(negedge clk);
    chk("z_b2b_ready0", 32'(z_req_ready), 32'd1);
    @(posedge clk); #1;
    z_req_addr = 32'h4;
    @(negedge clk);
    chk("z_b2b_valid0", 32'(z_rsp_valid), 32'd1);
    chk("z_b2b_rdata0", z_rsp_rdata, 32'h11111111);
    chk("z_b2b_busy", 32'(z_req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("z_b2b_ready1", 32'(z_req_ready), 32'd1);
    chk("z_b2b_gap", 32'(z_rsp_valid), 32'd0);
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    @(negedge clk);
    chk("z_b2b_valid1", 32'(z_rsp_valid), 32'd1);
    chk("z_b2b_rdata1", z_rsp_rdata, 32'h22222222);
    @(posedge clk); #1;

    // Reset while a store is waiting: the store must be dropped
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(negedge clk);
    chk("mid_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_in_wait", 32'(req_ready), 32'd0);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'h20, 32'h0, 3, 1'b0, 32'hAAAA5555, "mid_ld20");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
